// File: rtl/tnoc_vc_selector_pkg.sv
// Shared types and sizing helpers for the VC selector and its WRR arbiter.
package tnoc_vc_selector_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    function automatic int calc_vc_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Stored FIFO entry is {head, tail, flit}.
    function automatic int calc_entry_width(input int flit_width);
        return flit_width + 2;
    endfunction

endpackage

// File: rtl/tnoc_vc_wrr_arbiter.sv
// Weighted round-robin VC arbiter with packet lock; owner is held while a
// presented flit is stalled so the output stays stable under backpressure.
module tnoc_vc_wrr_arbiter
    import tnoc_vc_selector_pkg::*;
#(
    parameter  int CHANNELS     = 2,
    parameter  int WEIGHT_WIDTH = 4,
    localparam int VC_WIDTH     = calc_vc_width(CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0]              req,
    input  logic [CHANNELS*WEIGHT_WIDTH-1:0] weight,
    input  logic                             accept,
    input  logic                             tail,
    output logic [VC_WIDTH-1:0]              owner,
    output logic [CHANNELS-1:0]              owner_oh,
    output arb_state_e                       state
);

    logic [VC_WIDTH-1:0]     pointer;
    logic [WEIGHT_WIDTH-1:0] quantum;
    logic                    held;
    logic [VC_WIDTH-1:0]     held_owner;
    logic [WEIGHT_WIDTH-1:0] owner_weight;
    logic [VC_WIDTH-1:0]     idx;
    logic                    found;

    always_comb begin
        owner = pointer;
        idx   = '0;
        found = 1'b0;
        if (state == LOCKED) begin
            owner = pointer;
        end else if (held) begin
            owner = held_owner;
        end else if (quantum != '0 && req[pointer]) begin
            owner = pointer;
        end else begin
            // pointer+1 first, pointer itself last
            for (int i = 1; i <= CHANNELS; i++) begin
                if (int'(pointer) + i >= CHANNELS)
                    idx = VC_WIDTH'(int'(pointer) + i - CHANNELS);
                else
                    idx = VC_WIDTH'(int'(pointer) + i);
                if (!found && req[idx]) begin
                    owner = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign owner_oh = CHANNELS'(1) << owner;

    always_comb begin
        owner_weight = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (owner == VC_WIDTH'(v))
                owner_weight = weight[v*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        if (owner_weight == '0)
            owner_weight = WEIGHT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNLOCKED;
            pointer    <= '0;
            quantum    <= '0;
            held       <= 1'b0;
            held_owner <= '0;
        end else begin
            held       <= req[owner] & ~accept;
            held_owner <= owner;
            if (accept) begin
                pointer <= owner;
                if (owner != pointer)
                    quantum <= owner_weight - WEIGHT_WIDTH'(1);
                else if (tail && quantum != '0)
                    quantum <= quantum - WEIGHT_WIDTH'(1);
                state <= tail ? UNLOCKED : LOCKED;
            end
        end
    end

endmodule

// File: rtl/tnoc_vc_selector_wrr.sv
// Per-VC input FIFOs feeding one output through a WRR packet-lock arbiter.
// Optional output skid slice: define TNOC_VC_SELECTOR_WRR_OUTPUT_SLICE_EN.
module tnoc_vc_selector_wrr
    import tnoc_vc_selector_pkg::*;
#(
    parameter  int CHANNELS     = 2,
    parameter  int FLIT_WIDTH   = 64,
    parameter  int DEPTH        = 8,
    parameter  int THRESHOLD    = DEPTH - 2,
    parameter  int WEIGHT_WIDTH = 4,
    localparam int VC_WIDTH     = calc_vc_width(CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0]              i_valid,
    output logic [CHANNELS-1:0]              o_ready,
    input  logic [FLIT_WIDTH-1:0]            i_flit,
    input  logic                             i_head,
    input  logic                             i_tail,
    output logic [CHANNELS-1:0]              o_almost_full,
    input  logic [CHANNELS*WEIGHT_WIDTH-1:0] i_weight,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [VC_WIDTH-1:0]              o_vc,
    output logic [FLIT_WIDTH-1:0]            o_flit,
    output logic                             o_head,
    output logic                             o_tail
);

    localparam int ENTRY_W = calc_entry_width(FLIT_WIDTH);
    localparam int AW      = $clog2(DEPTH);

    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [FLIT_WIDTH-1:0] flit;
    } fifo_entry_t;

    logic [CHANNELS-1:0]              req;
    logic [CHANNELS-1:0]              owner_oh;
    logic [VC_WIDTH-1:0]              owner;
    logic [CHANNELS-1:0][ENTRY_W-1:0] head_entry;
    fifo_entry_t                      sel;
    logic                             mux_valid;
    logic                             mux_ready;
    logic                             accept;
    arb_state_e                       arb_state;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_fifo
        logic [ENTRY_W-1:0] mem [DEPTH];
        logic [AW:0]        wr_ptr;
        logic [AW:0]        rd_ptr;
        logic [AW:0]        count;
        logic               wr_en;
        logic               rd_en;

        assign count            = wr_ptr - rd_ptr;
        assign o_ready[v]       = (count != (AW+1)'(DEPTH));
        assign o_almost_full[v] = (count >= (AW+1)'(THRESHOLD));
        assign req[v]           = (count != '0);
        assign wr_en            = i_valid[v] & o_ready[v];
        assign rd_en            = accept & owner_oh[v];
        assign head_entry[v]    = mem[rd_ptr[AW-1:0]];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end

        // Storage needs no reset: pointers alone define what is valid.
        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_ptr[AW-1:0]] <= {i_head, i_tail, i_flit};
        end
    end

    tnoc_vc_wrr_arbiter #(
        .CHANNELS     (CHANNELS),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .weight   (i_weight),
        .accept   (accept),
        .tail     (sel.tail),
        .owner    (owner),
        .owner_oh (owner_oh),
        .state    (arb_state)
    );

    // Handshake: a flit moves when valid & ready are both high at a rising
    // edge; valid and payload stay constant while valid & ~ready.
    assign sel       = fifo_entry_t'(head_entry[owner]);
    assign mux_valid = req[owner];
    assign accept    = mux_valid & mux_ready;

`ifdef TNOC_VC_SELECTOR_WRR_OUTPUT_SLICE_EN
    localparam int SW = VC_WIDTH + ENTRY_W;

    logic [SW-1:0] mux_word;
    logic [SW-1:0] main_q;
    logic [SW-1:0] skid_q;
    logic          main_valid;
    logic          skid_valid;

    assign mux_word  = {owner, sel.head, sel.tail, sel.flit};
    assign mux_ready = ~skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid || i_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) main_q <= mux_word;
            end
        end else if (accept) begin
            skid_q     <= mux_word;
            skid_valid <= 1'b1;
        end
    end

    assign o_valid                        = main_valid;
    assign {o_vc, o_head, o_tail, o_flit} = main_q;
`else
    assign mux_ready = i_ready;
    assign o_valid   = mux_valid;
    assign o_vc      = owner;
    assign o_head    = mux_valid & sel.head;
    assign o_tail    = mux_valid & sel.tail;
    assign o_flit    = mux_valid ? sel.flit : '0;
`endif

endmodule

// File: tb/tb_tnoc_vc_selector_wrr.sv
// Directed bench for tnoc_vc_selector_wrr (default build, 2 VCs, DEPTH 8).
module tb_tnoc_vc_selector_wrr;

    localparam int CH = 2;
    localparam int FW = 64;
    localparam int WW = 4;
    localparam int VW = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    i_valid = '0;
    logic [CH-1:0]    o_ready;
    logic [FW-1:0]    i_flit = '0;
    logic             i_head = 1'b0;
    logic             i_tail = 1'b0;
    logic [CH-1:0]    o_almost_full;
    logic [CH*WW-1:0] i_weight = {4'd1, 4'd1};
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [VW-1:0]    o_vc;
    logic [FW-1:0]    o_flit;
    logic             o_head;
    logic             o_tail;

    int n_cmp = 0;
    int n_err = 0;

    logic [71:0] exp_q[$];
    logic [71:0] acc_q[$];
    logic [63:0] next_flit [CH];

    always #5 clk = ~clk;

    tnoc_vc_selector_wrr #(
        .CHANNELS     (CH),
        .FLIT_WIDTH   (FW),
        .DEPTH        (8),
        .THRESHOLD    (6),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_flit        (i_flit),
        .i_head        (i_head),
        .i_tail        (i_tail),
        .o_almost_full (o_almost_full),
        .i_weight      (i_weight),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_vc          (o_vc),
        .o_flit        (o_flit),
        .o_head        (o_head),
        .o_tail        (o_tail)
    );

    function automatic logic [71:0] ent(input int vc, input logic [63:0] f);
        return {8'(vc), f};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, log a transfer if one happens at the next edge.
    task automatic cyc(input logic [CH-1:0] v, input logic [63:0] f,
                       input logic h, input logic t, input logic r);
        i_valid = v;
        i_flit  = f;
        i_head  = h;
        i_tail  = t;
        i_ready = r;
        #1;
        if (o_valid && i_ready && !rst)
            acc_q.push_back({7'b0, o_vc, o_flit});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0, r);
    endtask

    task automatic check_stream(input string tag);
        chk($sformatf("%s_count", tag), 80'(acc_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 80'(acc_q[i]), 80'(exp_q[i]));
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
        i_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc_q.delete();
        exp_q.delete();
        next_flit[0] = 64'h100;
        next_flit[1] = 64'h200;
    endtask

    task automatic expect_vc(input int vc);
        exp_q.push_back(ent(vc, next_flit[vc]));
        next_flit[vc] = next_flit[vc] + 64'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_w [12];
        int seq_z [9];
        seq_w = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
        seq_z = '{0, 1, 1, 0, 1, 1, 0, 1, 1};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_o_valid", 80'(o_valid), 80'(0));
        chk("rst_o_ready", 80'(o_ready), 80'(2'b11));
        chk("rst_o_af", 80'(o_almost_full), 80'(0));
        chk("rst_o_vc", 80'(o_vc), 80'(0));
        chk("rst_o_flit", 80'(o_flit), 80'(0));
        chk("rst_o_ht", 80'({o_head, o_tail}), 80'(0));
        do_reset();

        // fill VC0 to full with output stalled
        for (int k = 0; k < 8; k++) begin
            cyc(2'b01, 64'h100 + 64'(k), 1'b1, 1'b1, 1'b0);
            exp_q.push_back(ent(0, 64'h100 + 64'(k)));
            chk($sformatf("fill_valid_%0d", k), 80'(o_valid), 80'(1));
            chk($sformatf("fill_vc_%0d", k), 80'(o_vc), 80'(0));
            chk($sformatf("fill_flit_%0d", k), 80'(o_flit), 80'(64'h100));
            chk($sformatf("fill_ready_%0d", k), 80'(o_ready), 80'({1'b1, k < 7}));
            chk($sformatf("fill_af_%0d", k), 80'(o_almost_full), 80'({1'b0, k >= 5}));
        end
        cyc(2'b01, 64'h1FF, 1'b1, 1'b1, 1'b0);
        chk("fill_overflow_ready", 80'(o_ready), 80'(2'b10));
        idle(10, 1'b1);
        check_stream("fill_drain");
        chk("drain_valid", 80'(o_valid), 80'(0));
        chk("drain_ready", 80'(o_ready), 80'(2'b11));
        chk("drain_af", 80'(o_almost_full), 80'(0));

        // packet lock: VC0 4-flit packet with VC1 single flit in between
        do_reset();
        i_weight = {4'd1, 4'd1};
        cyc(2'b01, 64'hA0, 1'b1, 1'b0, 1'b1);
        cyc(2'b01, 64'hA1, 1'b0, 1'b0, 1'b1);
        cyc(2'b10, 64'hB0, 1'b1, 1'b1, 1'b1);
        chk("lock_hold_valid", 80'(o_valid), 80'(0));
        cyc(2'b01, 64'hA2, 1'b0, 1'b0, 1'b1);
        cyc(2'b01, 64'hA3, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);
        exp_q.push_back(ent(0, 64'hA0));
        exp_q.push_back(ent(0, 64'hA1));
        exp_q.push_back(ent(0, 64'hA2));
        exp_q.push_back(ent(0, 64'hA3));
        exp_q.push_back(ent(1, 64'hB0));
        check_stream("lock");

        // weighted RR 3:1 with single-flit packets
        do_reset();
        i_weight = {4'd1, 4'd3};
        for (int k = 0; k < 8; k++) cyc(2'b01, 64'h100 + 64'(k), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(2'b10, 64'h200 + 64'(k), 1'b1, 1'b1, 1'b0);
        idle(14, 1'b1);
        for (int i = 0; i < 12; i++) expect_vc(seq_w[i]);
        check_stream("wrr31");

        // weight 0 treated as 1, VC1 weight 2
        do_reset();
        i_weight = {4'd2, 4'd0};
        for (int k = 0; k < 3; k++) cyc(2'b01, 64'h100 + 64'(k), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cyc(2'b10, 64'h200 + 64'(k), 1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);
        for (int i = 0; i < 9; i++) expect_vc(seq_z[i]);
        check_stream("wrr_w0");

        // backpressure mid-packet, VC1 arrives during the stall
        do_reset();
        i_weight = {4'd1, 4'd1};
        cyc(2'b01, 64'hC0, 1'b1, 1'b0, 1'b0);
        cyc(2'b01, 64'hC1, 1'b0, 1'b0, 1'b0);
        cyc(2'b01, 64'hC2, 1'b0, 1'b0, 1'b0);
        cyc(2'b01, 64'hC3, 1'b0, 1'b1, 1'b0);
        chk("bp_head_flit", 80'(o_flit), 80'(64'hC0));
        cyc('0, '0, 1'b0, 1'b0, 1'b1);
        chk("bp_c1_flit", 80'(o_flit), 80'(64'hC1));
        cyc(2'b10, 64'hD0, 1'b1, 1'b1, 1'b0);
        chk("bp_stall1_flit", 80'(o_flit), 80'(64'hC1));
        chk("bp_stall1_vc", 80'(o_vc), 80'(0));
        cyc('0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_stall2_flit", 80'(o_flit), 80'(64'hC1));
        chk("bp_stall2_vc", 80'(o_vc), 80'(0));
        chk("bp_stall2_valid", 80'(o_valid), 80'(1));
        idle(6, 1'b1);
        exp_q.push_back(ent(0, 64'hC0));
        exp_q.push_back(ent(0, 64'hC1));
        exp_q.push_back(ent(0, 64'hC2));
        exp_q.push_back(ent(0, 64'hC3));
        exp_q.push_back(ent(1, 64'hD0));
        check_stream("bp");

        // reset during flit 2 of a VC1 packet
        do_reset();
        cyc(2'b10, 64'hE0, 1'b1, 1'b0, 1'b1);
        cyc(2'b10, 64'hE1, 1'b0, 1'b0, 1'b1);
        cyc(2'b10, 64'hE2, 1'b0, 1'b0, 1'b1);
        chk("mid_flit2", 80'(o_flit), 80'(64'hE2));
        chk("mid_flit2_vc", 80'(o_vc), 80'(1));
        rst     = 1'b1;
        i_valid = '0;
        @(negedge clk);
        chk("mid_rst_valid", 80'(o_valid), 80'(0));
        chk("mid_rst_ready", 80'(o_ready), 80'(2'b11));
        chk("mid_rst_af", 80'(o_almost_full), 80'(0));
        rst = 1'b0;
        acc_q.delete();
        cyc(2'b01, 64'hF0, 1'b1, 1'b1, 1'b0);
        chk("mid_new_valid", 80'(o_valid), 80'(1));
        chk("mid_new_vc", 80'(o_vc), 80'(0));
        chk("mid_new_flit", 80'(o_flit), 80'(64'hF0));
        idle(3, 1'b1);
        exp_q.push_back(ent(0, 64'hF0));
        check_stream("mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
